msg_link_responder: RTL

//  Responding end of the one-wire machine-to-machine message link. Deserialises a

---
 rtl/msg_link_pkg.sv | 19 +
 rtl/msg_shift_in.sv | 36 +++
 rtl/msg_link_responder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/msg_link_pkg.sv
// Shared definitions for the one-wire message link (responder and future initiator).
// Optional feature macro: MSG_PARITY_EN (one even-parity bit after the data).
package msg_link_pkg;

    // Responder frame-reception states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        ACK    = 3'd4
    } link_state_t;

    // Line levels that delimit a frame.
    localparam logic START_BIT  = 1'b1;
    localparam logic STOP_BIT   = 1'b0;
    localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/msg_shift_in.sv
// Payload deserialiser: LSB-first shift register plus bit counter.
// last_bit is high while the counter points at the final payload bit.
module msg_shift_in
    import msg_link_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift,
    input  logic              bit_in,
    output logic [DATA_W-1:0] data,
    output logic              last_bit
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [CNT_W-1:0] bit_cnt;

    // Shift new bits in at the MSB so the first bit received ends at bit 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            data    <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            bit_cnt <= '0;
        end else if (shift) begin
            data    <= {bit_in, data[DATA_W-1:1]};
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/msg_link_responder.sv
// Responding end of the one-wire message link: receives a framed payload,
// buffers it for a valid/ready consumer and acknowledges good frames.
// Optional feature macro: MSG_PARITY_EN (even-parity bit checked before stop).
module msg_link_responder
    import msg_link_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ACK_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_line,
    output logic              ack_line,
    output logic [DATA_W-1:0] msg_data,
    output logic              msg_valid,
    input  logic              msg_ready,
    output logic              frame_err,
    output logic              overrun
);

    localparam int ACK_W = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;

    link_state_t       state, state_next;
    logic [ACK_W-1:0]  ack_cnt, ack_cnt_next;
    logic              shift_clear, shift_en, last_bit;
    logic [DATA_W-1:0] shift_data;
    logic              load_msg, err_next, ovr_next;
    logic              parity_ok, frame_good, buffer_free;

    msg_shift_in #(.DATA_W(DATA_W)) u_shift_in (
        .clock    (clock),
        .reset    (reset),
        .clear    (shift_clear),
        .shift    (shift_en),
        .bit_in   (rx_line),
        .data     (shift_data),
        .last_bit (last_bit)
    );

`ifdef MSG_PARITY_EN
    logic parity_load;
    logic parity_bit;

    // Capture the received parity bit for checking in STOP.
    always_ff @(posedge clock) begin
        if (reset) parity_bit <= 1'b0;
        else if (parity_load) parity_bit <= rx_line;
    end

    assign parity_ok = (parity_bit == ^shift_data);
`else
    assign parity_ok = 1'b1;
`endif

    assign frame_good  = (rx_line == STOP_BIT) && parity_ok;
    assign buffer_free = !msg_valid || msg_ready;
    assign ack_line    = (state == ACK);

    // State and ack-length counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            ack_cnt <= '0;
        end else begin
            state   <= state_next;
            ack_cnt <= ack_cnt_next;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_next   = state;
        ack_cnt_next = ack_cnt;
        shift_clear  = 1'b0;
        shift_en     = 1'b0;
        load_msg     = 1'b0;
        err_next     = 1'b0;
        ovr_next     = 1'b0;
`ifdef MSG_PARITY_EN
        parity_load  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rx_line == START_BIT) begin
                    shift_clear = 1'b1;
                    state_next  = DATA;
                end
            end
            DATA: begin
                shift_en = 1'b1;
                if (last_bit) begin
`ifdef MSG_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef MSG_PARITY_EN
            PARITY: begin
                parity_load = 1'b1;
                state_next  = STOP;
            end
`endif
            STOP: begin
                state_next = IDLE;
                if (!frame_good) begin
                    err_next = 1'b1;
                end else if (buffer_free) begin
                    load_msg     = 1'b1;
                    ack_cnt_next = '0;
                    state_next   = ACK;
                end else begin
                    ovr_next = 1'b1;
                end
            end
            ACK: begin
                if (ack_cnt == ACK_W'(ACK_CYCLES - 1)) state_next = IDLE;
                else ack_cnt_next = ack_cnt + ACK_W'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    // Message buffer and registered status pulses; a new load wins over a consume.
    always_ff @(posedge clock) begin
        if (reset) begin
            msg_data  <= '0;
            msg_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= err_next;
            overrun   <= ovr_next;
            if (load_msg) begin
                msg_data  <= shift_data;
                msg_valid <= 1'b1;
            end else if (msg_valid && msg_ready) begin
                msg_valid <= 1'b0;
            end
        end
    end

endmodule
